uart_link_fifo: RTL and testbench
=================================

// Module: uart_link_fifo
// PURPOSE
//  Parametrised full-duplex UART endpoint with TX and RX FIFOs, framing and overrun detection.
//  Next generation of the host-side serial model: synthesisable, with configurable baud, data width, stop bits and buffering.
//  Serves as the core's serial I/O port and as the computer-side stimulus/capture endpoint in system benches.
// PARAMETERS
//  CLK_PER_HALF_BIT  434  clk cycles per half bit; bit period = 2*CLK_PER_HALF_BIT (>=2)
//  DATA_BITS         8    payload bits per frame (5..9)
//  STOP_BITS         1    stop bits sent by TX (1 or 2); RX checks the first only
//  FIFO_DEPTH        16   entries per FIFO; power of 2, >=2
// PORTS
//  clk        in   1                  system clock
//  rst        in   1                  synchronous reset, active-high
//  rxd        in   1                  serial input, idle high, asynchronous
//  txd        out  1                  serial output, idle high
//  tx_data    in   DATA_BITS          byte to send
//  tx_valid   in   1                  tx_data valid
//  tx_ready   out  1                  TX FIFO not full
//  rx_data    out  DATA_BITS          head of RX FIFO
//  rx_valid   out  1                  RX FIFO not empty
//  rx_ready   in   1                  consumer pops head
//  tx_level   out  $clog2(FIFO_DEPTH)+1  TX FIFO occupancy
//  rx_level   out  $clog2(FIFO_DEPTH)+1  RX FIFO occupancy
//  frame_err  out  1                  sticky: stop bit sampled low
//  overrun    out  1                  sticky: RX byte dropped, FIFO full
//  clr_err    in   1                  clears frame_err and overrun next cycle
// BEHAVIOUR
//  Reset: txd=1, rx_valid=0, levels=0, frame_err=0, overrun=0, both FSMs IDLE, FIFOs empty. tx_ready=1 on the cycle after rst drops.
//  Reset mid-frame: TX aborts, txd=1 from the next cycle, truncated frame left on line. RX frame discarded. FIFO contents lost.
//  FIFOs: push on valid&&ready, pop on valid&&ready. Simultaneous push+pop: level unchanged. A push is accepted when full only if a pop happens in the same cycle.
//   Pointers wrap modulo FIFO_DEPTH. rx_data is stable while rx_valid && !rx_ready.
//  TX FSM, IDLE->START->DATA->STOP->IDLE:
//   IDLE: if TX FIFO non-empty, pop and load shift reg.
//   Accept at cycle N: txd goes low at N+2 (write N, load N+1).
//   START: txd=0 for 1 bit period. DATA: LSB first, DATA_BITS periods.
//   STOP: txd=1 for STOP_BITS periods.
//   Back-to-back: next start bit follows the last stop bit with no idle gap, since the pop occurs on the IDLE cycle.
//  RX path: 2-FF synchroniser on rxd, all detection on the synchronised value.
//  RX FSM, IDLE->START->DATA->STOP->IDLE:
//   IDLE: falling edge (1->0) starts the half-bit counter.
//   START: resample after CLK_PER_HALF_BIT cycles. Still 0: proceed. Is 1: glitch, back to IDLE, no flag.
//   DATA: sample every 2*CLK_PER_HALF_BIT cycles at mid-bit, LSB first.
//   STOP: sample at mid-bit.
//     If 1: push the byte. If the FIFO is full with no pop that cycle, drop it and set overrun.
//     If 0: set frame_err, discard the byte, wait for rxd=1 before re-arming IDLE (break condition).
//   rx_valid rises the cycle after a successful stop sample.
//  Flags: set has priority over clr_err in the same cycle.
//  tx_level/rx_level are registered and reflect the FIFOs after the current cycle's push/pop.
// TESTING
//  Use CLK_PER_HALF_BIT=4 (bit = 8 clk), DATA_BITS=8, FIFO_DEPTH=4 unless stated.
//  1. Loopback txd->rxd, push 0xA5, 0x3C, 0xFF, 0x00 -> rx pops the same 4 bytes in order, no flags. txd low exactly 2 cycles after the first accept.
//  2. Frame timing: push 0x55 with STOP_BITS=2 -> txd = 0,1,0,1,0,1,0,1,0 then 1,1, each held 8 cycles (88 cycles total); next start bit immediately after.
//  3. Framing error: drive start, 0x81, stop=0 -> frame_err=1, rx_level=0. Hold rxd=0 4 bits, then a valid 0x12 frame -> 0x12 received. clr_err -> frame_err=0.
//  4. Overrun: rx_ready=0, send 5 frames 0x01..0x05 -> rx_level=4, overrun=1, pops yield 0x01..0x04.
//  5. Glitch: rxd low for 2 cycles then high -> no byte, no flags, RX back in IDLE.
//  6. Reset mid-TX: assert rst during data bit 3 of 0xC3 -> txd=1 next cycle, tx_level=0, rx_valid=0. A new push afterwards transmits correctly.

Source files
------------

// File: rtl/uart_link_fifo.sv
// Full-duplex UART endpoint with TX/RX FIFOs.
// Sticky frame-error and overrun flags; configurable baud, width and stop bits.
module uart_link_fifo_buf #(
  parameter int W     = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic [W-1:0]             i_data,
  input  logic                     i_pop,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [W-1:0]             o_data,
  output logic [$clog2(DEPTH):0]   o_level
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wp;
  logic [AW-1:0] r_rp;
  logic [AW:0]   r_level;
  logic          w_wr;
  logic          w_rd;

  assign o_full  = (r_level == (AW+1)'(DEPTH));
  assign o_empty = (r_level == '0);
  assign o_data  = r_mem[r_rp];
  assign o_level = r_level;

  // A full FIFO still accepts a push when the head leaves this cycle.
  assign w_rd = i_pop && !o_empty;
  assign w_wr = i_push && (!o_full || w_rd);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_level <= '0;
    end else begin
      if (w_wr) r_wp <= r_wp + AW'(1);
      if (w_rd) r_rp <= r_rp + AW'(1);
      r_level <= r_level + (AW+1)'(w_wr) - (AW+1)'(w_rd);
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wp] <= i_data;
  end
endmodule

module uart_link_fifo #(
  parameter int CLK_PER_HALF_BIT = 434,
  parameter int DATA_BITS        = 8,
  parameter int STOP_BITS        = 1,
  parameter int FIFO_DEPTH       = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          rxd,
  output logic                          txd,
  input  logic [DATA_BITS-1:0]          tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic [DATA_BITS-1:0]          rx_data,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  output logic [$clog2(FIFO_DEPTH):0]   tx_level,
  output logic [$clog2(FIFO_DEPTH):0]   rx_level,
  output logic                          frame_err,
  output logic                          overrun,
  input  logic                          clr_err
);
  localparam int BIT = 2 * CLK_PER_HALF_BIT;
  localparam int CW  = $clog2(BIT);
  localparam int BW  = $clog2(DATA_BITS + 1);

  typedef enum logic [1:0] {
    TX_IDLE, TX_START, TX_DATA, TX_STOP
  } tx_st_t;

  typedef enum logic [2:0] {
    RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_BREAK
  } rx_st_t;

  // ---------------- FIFOs ----------------
  logic                 w_txf_full;
  logic                 w_txf_empty;
  logic [DATA_BITS-1:0] w_txf_data;
  logic                 w_tx_pop;
  logic                 w_rxf_full;
  logic                 w_rxf_empty;
  logic                 w_rx_pop;
  logic                 w_rx_done;

  uart_link_fifo_buf #(
    .W     (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_txf (
    .clk     (clk),
    .rst     (rst),
    .i_push  (tx_valid),
    .i_data  (tx_data),
    .i_pop   (w_tx_pop),
    .o_full  (w_txf_full),
    .o_empty (w_txf_empty),
    .o_data  (w_txf_data),
    .o_level (tx_level)
  );

  logic [DATA_BITS-1:0] r_rx_sh;

  uart_link_fifo_buf #(
    .W     (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_rxf (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_rx_done),
    .i_data  (r_rx_sh),
    .i_pop   (w_rx_pop),
    .o_full  (w_rxf_full),
    .o_empty (w_rxf_empty),
    .o_data  (rx_data),
    .o_level (rx_level)
  );

  assign tx_ready = !w_txf_full || w_tx_pop;
  assign rx_valid = !w_rxf_empty;
  assign w_rx_pop = rx_ready && !w_rxf_empty;

  // ---------------- TX ----------------
  tx_st_t               r_tx_st;
  tx_st_t               w_tx_nxt;
  logic [CW-1:0]        r_tx_cnt;
  logic [BW-1:0]        r_tx_bits;
  logic [DATA_BITS-1:0] r_tx_sh;
  logic                 r_txd;
  logic                 w_tx_end;
  logic                 w_tx_last;
  logic                 w_tx_sdone;

  assign w_tx_end  = (r_tx_cnt == CW'(BIT - 1));
  assign w_tx_last = (r_tx_bits == BW'(DATA_BITS - 1));
  // Last stop bit ends one cycle early: the IDLE pop cycle supplies it.
  assign w_tx_sdone = (r_tx_cnt == CW'(BIT - 2)) &&
                      (r_tx_bits == BW'(STOP_BITS - 1));
  assign txd = r_txd;

  always_ff @(posedge clk) begin
    if (rst) r_tx_st <= TX_IDLE;
    else     r_tx_st <= w_tx_nxt;
  end

  always_comb begin
    w_tx_nxt = r_tx_st;
    w_tx_pop = 1'b0;
    unique case (r_tx_st)
      TX_IDLE: begin
        if (!w_txf_empty) begin
          w_tx_pop = 1'b1;
          w_tx_nxt = TX_START;
        end
      end
      TX_START: if (w_tx_end) w_tx_nxt = TX_DATA;
      TX_DATA:  if (w_tx_end && w_tx_last) w_tx_nxt = TX_STOP;
      TX_STOP:  if (w_tx_sdone) w_tx_nxt = TX_IDLE;
      default:  w_tx_nxt = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_txd     <= 1'b1;
      r_tx_cnt  <= '0;
      r_tx_bits <= '0;
      r_tx_sh   <= '0;
    end else begin
      unique case (r_tx_st)
        TX_IDLE: begin
          if (w_tx_pop) begin
            r_tx_sh   <= w_txf_data;
            r_txd     <= 1'b0;
            r_tx_cnt  <= '0;
            r_tx_bits <= '0;
          end
        end
        TX_START: begin
          if (w_tx_end) begin
            r_tx_cnt <= '0;
            r_txd    <= r_tx_sh[0];
          end else begin
            r_tx_cnt <= r_tx_cnt + CW'(1);
          end
        end
        TX_DATA: begin
          if (w_tx_end) begin
            r_tx_cnt <= '0;
            if (w_tx_last) begin
              r_txd     <= 1'b1;
              r_tx_bits <= '0;
            end else begin
              r_tx_sh   <= r_tx_sh >> 1;
              r_txd     <= r_tx_sh[1];
              r_tx_bits <= r_tx_bits + BW'(1);
            end
          end else begin
            r_tx_cnt <= r_tx_cnt + CW'(1);
          end
        end
        TX_STOP: begin
          if (w_tx_end) begin
            r_tx_cnt  <= '0;
            r_tx_bits <= r_tx_bits + BW'(1);
          end else begin
            r_tx_cnt <= r_tx_cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // ---------------- RX ----------------
  logic          r_rx_s1;
  logic          r_rx_s2;
  logic          r_rx_s3;
  logic          w_rx;
  logic          w_fall;
  rx_st_t        r_rx_st;
  rx_st_t        w_rx_nxt;
  logic [CW-1:0] r_rx_cnt;
  logic [BW-1:0] r_rx_bits;
  logic          w_rx_half;
  logic          w_rx_end;
  logic          w_rx_last;
  logic          w_ferr_set;
  logic          w_ovr_set;

  assign w_rx      = r_rx_s2;
  assign w_fall    = r_rx_s3 && !r_rx_s2;
  assign w_rx_half = (r_rx_cnt == CW'(CLK_PER_HALF_BIT - 1));
  assign w_rx_end  = (r_rx_cnt == CW'(BIT - 1));
  assign w_rx_last = (r_rx_bits == BW'(DATA_BITS - 1));
  assign w_ovr_set = w_rx_done && w_rxf_full && !w_rx_pop;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_s1 <= 1'b1;
      r_rx_s2 <= 1'b1;
      r_rx_s3 <= 1'b1;
      r_rx_st <= RX_IDLE;
    end else begin
      r_rx_s1 <= rxd;
      r_rx_s2 <= r_rx_s1;
      r_rx_s3 <= r_rx_s2;
      r_rx_st <= w_rx_nxt;
    end
  end

  always_comb begin
    w_rx_nxt   = r_rx_st;
    w_rx_done  = 1'b0;
    w_ferr_set = 1'b0;
    unique case (r_rx_st)
      RX_IDLE:  if (w_fall) w_rx_nxt = RX_START;
      RX_START: if (w_rx_half) w_rx_nxt = w_rx ? RX_IDLE : RX_DATA;
      RX_DATA:  if (w_rx_end && w_rx_last) w_rx_nxt = RX_STOP;
      RX_STOP: begin
        if (w_rx_end) begin
          if (w_rx) begin
            w_rx_done = 1'b1;
            w_rx_nxt  = RX_IDLE;
          end else begin
            w_ferr_set = 1'b1;
            w_rx_nxt   = RX_BREAK;
          end
        end
      end
      RX_BREAK: if (w_rx) w_rx_nxt = RX_IDLE;
      default:  w_rx_nxt = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_cnt  <= '0;
      r_rx_bits <= '0;
      r_rx_sh   <= '0;
    end else begin
      unique case (r_rx_st)
        RX_START: begin
          if (w_rx_half) begin
            r_rx_cnt  <= '0;
            r_rx_bits <= '0;
          end else begin
            r_rx_cnt <= r_rx_cnt + CW'(1);
          end
        end
        RX_DATA: begin
          if (w_rx_end) begin
            r_rx_cnt  <= '0;
            r_rx_sh   <= {w_rx, r_rx_sh[DATA_BITS-1:1]};
            r_rx_bits <= r_rx_bits + BW'(1);
          end else begin
            r_rx_cnt <= r_rx_cnt + CW'(1);
          end
        end
        RX_STOP: begin
          if (w_rx_end) r_rx_cnt <= '0;
          else          r_rx_cnt <= r_rx_cnt + CW'(1);
        end
        default: r_rx_cnt <= '0;
      endcase
    end
  end

  // ---------------- sticky flags ----------------
  logic r_ferr;
  logic r_ovr;

  assign frame_err = r_ferr;
  assign overrun   = r_ovr;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ferr <= 1'b0;
      r_ovr  <= 1'b0;
    end else begin
      if (w_ferr_set)   r_ferr <= 1'b1;
      else if (clr_err) r_ferr <= 1'b0;
      if (w_ovr_set)    r_ovr  <= 1'b1;
      else if (clr_err) r_ovr  <= 1'b0;
    end
  end
endmodule

// File: tb/tb_uart_link_fifo.sv
// Scoreboard bench for uart_link_fifo: expected RX bytes queued at stimulus,
// popped by a monitor on each rx_valid && rx_ready handshake.
module tb_uart_link_fifo;
  localparam int BIT = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rxd;
  logic       txd;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready = 1'b0;
  logic [2:0] tx_level;
  logic [2:0] rx_level;
  logic       frame_err;
  logic       overrun;
  logic       clr_err = 1'b0;

  logic loop = 1'b0;
  logic drv  = 1'b1;
  assign rxd = loop ? txd : drv;

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] exp_q[$];
  logic [7:0] mon_e;
  logic [10:0] pat;

  always #5 clk = ~clk;

  uart_link_fifo #(
    .CLK_PER_HALF_BIT (4),
    .DATA_BITS        (8),
    .STOP_BITS        (2),
    .FIFO_DEPTH       (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rxd       (rxd),
    .txd       (txd),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .tx_level  (tx_level),
    .rx_level  (rx_level),
    .frame_err (frame_err),
    .overrun   (overrun),
    .clr_err   (clr_err)
  );

  always @(negedge clk) begin
    if (!rst && rx_valid && rx_ready) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL rx_unexpected: got %02h want none", rx_data);
      end else begin
        mon_e = exp_q.pop_front();
        if (rx_data !== mon_e) begin
          n_bad++;
          $display("FAIL rx_data: got %02h want %02h", rx_data, mon_e);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] b);
    logic r;
    r = 1'b0;
    tx_data  = b;
    tx_valid = 1'b1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk) r = tx_ready;
      @(posedge clk);
      #1;
      if (r) break;
    end
    tx_valid = 1'b0;
    if (!r) begin
      n_cmp++;
      n_bad++;
      $display("FAIL push_timeout: got not-ready want accept of %02h", b);
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    drv = 1'b0;
    tick(BIT);
    for (int i = 0; i < 8; i++) begin
      drv = d[i];
      tick(BIT);
    end
    drv = stop;
    tick(BIT);
    drv = 1'b1;
  endtask

  task automatic wait_drain(input int max);
    for (int i = 0; i < max; i++) begin
      if (exp_q.size() == 0) break;
      tick(1);
    end
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain_timeout: got %0d pending want 0", exp_q.size());
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset
    tick(3);
    rst = 1'b0;
    tick(1);
    chk("rst_txd", txd, 1);
    chk("rst_rx_valid", rx_valid, 0);
    chk("rst_tx_level", tx_level, 0);
    chk("rst_rx_level", rx_level, 0);
    chk("rst_frame_err", frame_err, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_tx_ready", tx_ready, 1);

    // 1: loopback of four bytes, start-bit latency
    loop = 1'b1;
    rx_ready = 1'b1;
    exp_q.push_back(8'hA5);
    push(8'hA5);
    chk("t1_txd_n1", txd, 1);
    tick(1);
    chk("t1_txd_n2", txd, 0);
    exp_q.push_back(8'h3C);
    push(8'h3C);
    exp_q.push_back(8'hFF);
    push(8'hFF);
    exp_q.push_back(8'h00);
    push(8'h00);
    wait_drain(1000);
    tick(3 * BIT);
    chk("t1_frame_err", frame_err, 0);
    chk("t1_overrun", overrun, 0);
    chk("t1_tx_level", tx_level, 0);

    // 2: frame timing 0x55, two stop bits, back-to-back 0x0F
    pat = 11'h6AA;
    exp_q.push_back(8'h55);
    push(8'h55);
    exp_q.push_back(8'h0F);
    push(8'h0F);
    for (int i = 0; i < 88; i++) begin
      if (i > 0) tick(1);
      chk($sformatf("t2_txd_c%0d", i), txd, pat[i/8]);
    end
    tick(1);
    chk("t2_next_start", txd, 0);
    wait_drain(500);
    tick(3 * BIT);

    // 3: framing error, break, recovery, clear
    loop = 1'b0;
    drv = 1'b1;
    tick(2 * BIT);
    send_frame(8'h81, 1'b0);
    drv = 1'b0;
    tick(4 * BIT);
    chk("t3_frame_err", frame_err, 1);
    chk("t3_rx_level", rx_level, 0);
    drv = 1'b1;
    tick(2 * BIT);
    exp_q.push_back(8'h12);
    send_frame(8'h12, 1'b1);
    tick(2 * BIT);
    wait_drain(200);
    chk("t3_sticky", frame_err, 1);
    clr_err = 1'b1;
    tick(1);
    clr_err = 1'b0;
    chk("t3_cleared", frame_err, 0);

    // 4: overrun with consumer stalled
    rx_ready = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      if (i <= 4) exp_q.push_back(8'(i));
      send_frame(8'(i), 1'b1);
    end
    tick(2 * BIT);
    chk("t4_rx_level", rx_level, 4);
    chk("t4_overrun", overrun, 1);
    chk("t4_rx_valid", rx_valid, 1);
    rx_ready = 1'b1;
    wait_drain(100);
    tick(2);
    chk("t4_rx_level_empty", rx_level, 0);
    clr_err = 1'b1;
    tick(1);
    clr_err = 1'b0;
    chk("t4_overrun_clr", overrun, 0);

    // 5: start-bit glitch
    drv = 1'b0;
    tick(2);
    drv = 1'b1;
    tick(3 * BIT);
    chk("t5_frame_err", frame_err, 0);
    chk("t5_overrun", overrun, 0);
    chk("t5_rx_level", rx_level, 0);
    exp_q.push_back(8'h5A);
    send_frame(8'h5A, 1'b1);
    tick(2 * BIT);
    wait_drain(100);

    // 6: reset during data bit 3 of 0xC3
    rx_ready = 1'b0;
    loop = 1'b1;
    tick(2 * BIT);
    push(8'h77);
    push(8'hC3);
    push(8'h99);
    tick(123);
    chk("t6_bit3", txd, 0);
    chk("t6_tx_level", tx_level, 1);
    chk("t6_rx_valid", rx_valid, 1);
    rst = 1'b1;
    tick(1);
    chk("t6_rst_txd", txd, 1);
    chk("t6_rst_tx_level", tx_level, 0);
    chk("t6_rst_rx_valid", rx_valid, 0);
    chk("t6_rst_rx_level", rx_level, 0);
    rst = 1'b0;
    tick(1);
    rx_ready = 1'b1;
    exp_q.push_back(8'h3C);
    push(8'h3C);
    wait_drain(300);
    tick(3 * BIT);
    chk("t6_frame_err", frame_err, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
